fw_sample_sequencer: RTL and testbench
======================================

// Module: fw_sample_sequencer
// PURPOSE
// - Controller between a host sample stream and the fuzzy-wavelet datapath.
// - Accepts 8-bit samples (valid/ready) and clocks each into the datapath: drives fw_value, then pulses fw_data_clk.
// - Then sweeps fw_select over NUM_SEL one-hot wavelet selections.
// - Emits one captured fw_out per selection on a valid/ready result stream, tagged with the selection index.
// PARAMETERS
// - NUM_SEL     8  selections swept per sample; range 1..8; fw_select = 1<<idx
// - SETUP_CYC   2  cycles fw_value is stable with fw_data_clk low before the pulse; >=1
// - PULSE_CYC   2  cycles fw_data_clk is held high; >=1
// - SETTLE_CYC  3  cycles after a fw_select change before fw_out is captured; >=1
// PORTS
// - clk           in   1  single clock, rising edge
// - rst           in   1  asynchronous, active-high reset
// - s_valid       in   1  host sample valid
// - s_data        in   8  host sample
// - s_ready       out  1  sequencer can accept a sample (IDLE only)
// - fw_value      out  8  sample presented to the datapath
// - fw_data_clk   out  1  datapath data strobe (registered, glitch-free)
// - fw_select     out  8  one-hot wavelet select to the datapath
// - fw_out        in   8  datapath result
// - fw_active     in   1  datapath activity flag
// - m_valid       out  1  result valid
// - m_data        out  8  captured fw_out
// - m_sel         out  3  selection index of m_data
// - m_active      out  1  fw_active captured with m_data
// - busy          out  1  high in every state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE; s_ready=1; fw_value=0; fw_data_clk=0; fw_select=0; m_valid=0; m_data=0; m_sel=0; m_active=0; busy=0.
// - Reset takes effect immediately, including mid-pulse: fw_data_clk drops asynchronously and any pending result is discarded.
// - All outputs are registered. State/count transitions occur on the rising clk edge.
// - IDLE: s_ready=1. On s_valid&&s_ready: latch s_data into fw_value -> SETUP; s_ready falls the next cycle.
// - SETUP: SETUP_CYC cycles, fw_data_clk=0 -> PULSE.
// - PULSE: PULSE_CYC cycles, fw_data_clk=1; fw_value held -> HOLD.
// - HOLD: 1 cycle, fw_data_clk=0, fw_value held; idx=0; fw_select<=1 -> SETTLE.
// - SETTLE: SETTLE_CYC cycles. On the last cycle, capture fw_out->m_data, fw_active->m_active, idx->m_sel -> EMIT.
// - EMIT: m_valid=1. m_data, m_sel and m_active stay stable until m_ready.
//   - On m_valid&&m_ready with idx<NUM_SEL-1: idx++, fw_select<=1<<idx -> SETTLE.
//   - Handshake with idx==NUM_SEL-1: fw_select<=0 -> IDLE.
// - m_valid deasserts the cycle after the accepting handshake. There are no back-to-back results.
// - Latency: handshake edge T0 to first m_valid rise = SETUP_CYC+PULSE_CYC+1+SETTLE_CYC cycles (8 at defaults).
// - With m_ready tied high, each further result follows SETTLE_CYC+1 cycles later.
// - m_ready low stalls indefinitely: no timeout, no data loss, fw_select held.
// - s_valid while busy is ignored (not queued). The host holds s_valid until s_ready.
// - fw_value changes only in IDLE on a handshake. It is never altered while fw_data_clk=1 or during SETUP/HOLD.
// - Exactly one fw_data_clk pulse is issued per accepted sample.
// CONFIGURATION
// - FWSEQ_ACTIVE_GATE_EN defined:
//   - In SETTLE, a capture with fw_active=0 is discarded. The selection is skipped without asserting m_valid:
//     idx advances, or the block returns to IDLE after the last index.
//   - m_active is then always 1.
// - FWSEQ_ACTIVE_GATE_EN undefined: every selection is emitted; m_active reports the fw_active sample.
// TESTING
// - Reset: rst=1 mid-PULSE -> fw_data_clk=0 immediately; all outputs at reset values; s_ready=1 on first edge after release.
// - Single sample: s_data=0x5A, m_ready=1, defaults.
//   - fw_value=0x5A; fw_data_clk high exactly 2 cycles, starting 2 cycles after the handshake.
//   - First m_valid 8 cycles after the handshake.
//   - 8 results, m_sel 0..7, each 4 cycles apart; fw_select sequence 0x01..0x80 then 0x00.
// - Back-pressure: m_ready=0 for 20 cycles on result 3 -> m_valid, m_data, m_sel=3 and fw_select=0x08 all stable; resumes on m_ready.
// - Busy input: s_valid=1 with 0xFF held during a sweep -> not accepted until IDLE; exactly one fw_data_clk pulse per sample.
// - NUM_SEL=1, SETUP_CYC=PULSE_CYC=SETTLE_CYC=1 -> one result 4 cycles after the handshake; back in IDLE the cycle after acceptance.
// - FWSEQ_ACTIVE_GATE_EN, fw_active=0 for selections 2 and 5 -> 6 results with m_sel {0,1,3,4,6,7}; busy falls after idx 7.

Source files
------------

// File: rtl/fw_sample_sequencer_if.sv
`default_nettype none
// ============================================================================
// fw_sample_sequencer_if : sample / datapath / result signal bundle
// Rev 1.0 - initial release
// ============================================================================
interface fw_sample_sequencer_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] fw_value;
  logic       fw_data_clk;
  logic [7:0] fw_select;
  logic [7:0] fw_out;
  logic       fw_active;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [2:0] m_sel;
  logic       m_active;
  logic       busy;

  // Sequencer side
  modport slave (
    input  s_valid, s_data, fw_out, fw_active, m_ready,
    output s_ready, fw_value, fw_data_clk, fw_select,
           m_valid, m_data, m_sel, m_active, busy
  );

  // Host / datapath side
  modport master (
    output s_valid, s_data, fw_out, fw_active, m_ready,
    input  s_ready, fw_value, fw_data_clk, fw_select,
           m_valid, m_data, m_sel, m_active, busy
  );
endinterface
`default_nettype wire

// File: rtl/fw_sample_sequencer.sv
`default_nettype none
// ============================================================================
// fw_sample_sequencer : clocks host samples into the fuzzy-wavelet datapath and
// sweeps one-hot selections, emitting one result per selection.
// Option macro FWSEQ_ACTIVE_GATE_EN : drop captures taken with fw_active=0.
// Rev 1.0 - initial release
// ============================================================================
module fw_sample_sequencer #(
  parameter int NUM_SEL    = 8,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  fw_sample_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_PULSE  = 3'd2,
    S_HOLD   = 3'd3,
    S_SETTLE = 3'd4,
    S_EMIT   = 3'd5
  } state_t;

  localparam int              c_CNT_W      = 16;
  localparam logic [2:0]         c_LAST_IDX   = 3'(NUM_SEL - 1);
  localparam logic [c_CNT_W-1:0] c_SETUP_END  = c_CNT_W'(SETUP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_PULSE_END  = c_CNT_W'(PULSE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_END = c_CNT_W'(SETTLE_CYC - 1);

  state_t             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]         r_idx, w_idx_nxt;
  logic [2:0]         w_idx_inc;
  logic [7:0]         r_fw_value, w_fw_value_nxt;
  logic [7:0]         r_fw_select, w_fw_select_nxt;
  logic               r_s_ready, r_busy, r_fw_data_clk, r_m_valid, r_m_active;
  logic [7:0]         r_m_data;
  logic [2:0]         r_m_sel;
  logic               w_capture;

  assign w_idx_inc = r_idx + 3'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + c_CNT_W'(1);
    w_idx_nxt       = r_idx;
    w_fw_value_nxt  = r_fw_value;
    w_fw_select_nxt = r_fw_select;
    w_capture       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_s_ready && bus.s_valid) begin
          w_fw_value_nxt = bus.s_data;
          w_state_nxt    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == c_SETUP_END) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_PULSE;
        end
      end
      S_PULSE: begin
        if (r_cnt == c_PULSE_END) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        w_cnt_nxt       = '0;
        w_idx_nxt       = 3'd0;
        w_fw_select_nxt = 8'd1;
        w_state_nxt     = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == c_SETTLE_END) begin
          w_cnt_nxt = '0;
`ifdef FWSEQ_ACTIVE_GATE_EN
          // Inactive capture: skip this selection and settle on the next one
          if (!bus.fw_active) begin
            if (r_idx == c_LAST_IDX) begin
              w_fw_select_nxt = 8'd0;
              w_state_nxt     = S_IDLE;
            end else begin
              w_idx_nxt       = w_idx_inc;
              w_fw_select_nxt = 8'd1 << w_idx_inc;
            end
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_EMIT;
          end
`else
          w_capture   = 1'b1;
          w_state_nxt = S_EMIT;
`endif
        end
      end
      S_EMIT: begin
        w_cnt_nxt = '0;
        if (r_m_valid && bus.m_ready) begin
          if (r_idx == c_LAST_IDX) begin
            w_fw_select_nxt = 8'd0;
            w_state_nxt     = S_IDLE;
          end else begin
            w_idx_nxt       = w_idx_inc;
            w_fw_select_nxt = 8'd1 << w_idx_inc;
            w_state_nxt     = S_SETTLE;
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Status outputs are decoded from the next state so they stay registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_idx         <= 3'd0;
      r_fw_value    <= 8'd0;
      r_fw_select   <= 8'd0;
      r_s_ready     <= 1'b1;
      r_busy        <= 1'b0;
      r_fw_data_clk <= 1'b0;
      r_m_valid     <= 1'b0;
      r_m_data      <= 8'd0;
      r_m_sel       <= 3'd0;
      r_m_active    <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_fw_value    <= w_fw_value_nxt;
      r_fw_select   <= w_fw_select_nxt;
      r_s_ready     <= (w_state_nxt == S_IDLE);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_fw_data_clk <= (w_state_nxt == S_PULSE);
      r_m_valid     <= (w_state_nxt == S_EMIT);
      if (w_capture) begin
        r_m_data   <= bus.fw_out;
        r_m_active <= bus.fw_active;
        r_m_sel    <= r_idx;
      end
    end
  end

  assign bus.s_ready     = r_s_ready;
  assign bus.busy        = r_busy;
  assign bus.fw_value    = r_fw_value;
  assign bus.fw_data_clk = r_fw_data_clk;
  assign bus.fw_select   = r_fw_select;
  assign bus.m_valid     = r_m_valid;
  assign bus.m_data      = r_m_data;
  assign bus.m_sel       = r_m_sel;
  assign bus.m_active    = r_m_active;

endmodule
`default_nettype wire

// File: tb/tb_fw_sample_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fw_sample_sequencer : scoreboard bench for fw_sample_sequencer
// Rev 1.0 - initial release
// ============================================================================
module tb_fw_sample_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int n_results = 0;
  int n_pulses = 0;
  logic [7:0]  act_mask = 8'hFF;
  logic [11:0] sb_q[$];

  fw_sample_sequencer_if u_if ();
  fw_sample_sequencer_if u_if1 ();

  function automatic logic [7:0] dp_model(input logic [7:0] v, input logic [7:0] s);
    return (v ^ {s[3:0], s[7:4]}) + 8'h01;
  endfunction

  assign u_if.fw_out     = dp_model(u_if.fw_value, u_if.fw_select);
  assign u_if.fw_active  = |(u_if.fw_select & act_mask);
  assign u_if1.fw_out    = dp_model(u_if1.fw_value, u_if1.fw_select);
  assign u_if1.fw_active = 1'b1;

  fw_sample_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  fw_sample_sequencer #(
    .NUM_SEL    (1),
    .SETUP_CYC  (1),
    .PULSE_CYC  (1),
    .SETTLE_CYC (1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (u_if1.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_sweep(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      logic a;
      a = act_mask[i];
`ifdef FWSEQ_ACTIVE_GATE_EN
      if (a) sb_q.push_back({a, 3'(i), dp_model(v, 8'd1 << i)});
`else
      sb_q.push_back({a, 3'(i), dp_model(v, 8'd1 << i)});
`endif
    end
  endtask

  // Monitor: push on accepted sample, pop/compare on accepted result
  initial begin
    logic       prev_dclk;
    logic [11:0] e;
    prev_dclk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (u_if.s_valid && u_if.s_ready) push_sweep(u_if.s_data);
        if (u_if.m_valid && u_if.m_ready) begin
          n_results++;
          if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check_val("m_sel", u_if.m_sel, e[10:8]);
            check_val("m_data", u_if.m_data, e[7:0]);
            check_val("m_active", u_if.m_active, e[11]);
            check_val("emit_select", u_if.fw_select, 8'd1 << u_if.m_sel);
          end
        end
        if (u_if.fw_data_clk && !prev_dclk) n_pulses++;
      end
      prev_dclk = u_if.fw_data_clk;
    end
  end

  task automatic send_sample(input logic [7:0] v, output int c0);
    bit done;
    done = 0;
    c0 = -1;
    @(posedge clk); #1;
    u_if.s_data  = v;
    u_if.s_valid = 1'b1;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (u_if.s_ready) begin
        @(posedge clk); #1;
        u_if.s_valid = 1'b0;
        c0 = cyc;
        done = 1;
      end
    end
    if (!done) check_val("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 0;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (!u_if.busy) done = 1;
    end
    check_val(tag, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, rel, first_dclk, dclk_hi, p0, r0, stable;
    int rises[$];
    logic [7:0] sel_seen[$];
    logic [7:0] last_sel, d0, exp_sel;
    logic prev_mv;
    bit done, found;

    u_if.s_valid  = 1'b0; u_if.s_data  = 8'd0; u_if.m_ready  = 1'b1;
    u_if1.s_valid = 1'b0; u_if1.s_data = 8'd0; u_if1.m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_s_ready", u_if.s_ready, 1'b1);
    check_val("rst_busy", u_if.busy, 1'b0);
    check_val("rst_fw_value", u_if.fw_value, 8'd0);
    check_val("rst_dclk", u_if.fw_data_clk, 1'b0);
    check_val("rst_select", u_if.fw_select, 8'd0);
    check_val("rst_m_valid", u_if.m_valid, 1'b0);
    check_val("rst_m_data", u_if.m_data, 8'd0);
    check_val("rst_m_sel", u_if.m_sel, 3'd0);
    check_val("rst_m_active", u_if.m_active, 1'b0);
    rst = 1'b0;

    // Single sample, free-flowing results
    send_sample(8'h5A, c0);
    check_val("t1_fw_value", u_if.fw_value, 8'h5A);
    first_dclk = -1; dclk_hi = 0; prev_mv = 1'b0; last_sel = 8'd0; done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      rel = cyc - c0;
      if (u_if.fw_data_clk) begin
        if (first_dclk < 0) first_dclk = rel;
        dclk_hi++;
      end
      if (u_if.m_valid && !prev_mv) rises.push_back(rel);
      prev_mv = u_if.m_valid;
      if (u_if.fw_select != last_sel) begin
        sel_seen.push_back(u_if.fw_select);
        last_sel = u_if.fw_select;
      end
      if (!u_if.busy) done = 1;
    end
    check_val("t1_idle", done, 1'b1);
    check_val("t1_dclk_start", first_dclk, 2);
    check_val("t1_dclk_width", dclk_hi, 2);
    check_val("t1_n_results", rises.size(), 8);
    if (rises.size() > 0) check_val("t1_first_latency", rises[0], 8);
    for (int i = 1; i < rises.size(); i++) check_val("t1_spacing", rises[i] - rises[i-1], 4);
    check_val("t1_sel_seq_len", sel_seen.size(), 9);
    for (int i = 0; i < sel_seen.size(); i++) begin
      exp_sel = (i < 8) ? (8'd1 << i) : 8'd0;
      check_val("t1_sel_seq", sel_seen[i], exp_sel);
    end
    check_val("t1_drain", sb_q.size(), 0);

    // Asynchronous reset in the middle of the data pulse
    send_sample(8'h42, c0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (u_if.fw_data_clk) found = 1;
    end
    check_val("t2_pulse_seen", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_val("t2_dclk_async", u_if.fw_data_clk, 1'b0);
    check_val("t2_s_ready", u_if.s_ready, 1'b1);
    check_val("t2_busy", u_if.busy, 1'b0);
    check_val("t2_fw_value", u_if.fw_value, 8'd0);
    check_val("t2_select", u_if.fw_select, 8'd0);
    check_val("t2_m_valid", u_if.m_valid, 1'b0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("t2_post_s_ready", u_if.s_ready, 1'b1);
    check_val("t2_post_busy", u_if.busy, 1'b0);

    // Back-pressure on result 3
    r0 = n_results;
    send_sample(8'h3C, c0);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk); #1;
      if (u_if.m_valid && u_if.m_sel == 3'd3) begin
        u_if.m_ready = 1'b0;
        found = 1;
      end
    end
    check_val("t3_reach_sel3", found, 1'b1);
    d0 = u_if.m_data;
    stable = 0;
    repeat (20) begin
      @(negedge clk);
      if (u_if.m_valid && u_if.m_data == d0 && u_if.m_sel == 3'd3 && u_if.fw_select == 8'h08)
        stable++;
    end
    check_val("t3_stall_stable", stable, 20);
    @(posedge clk); #1;
    u_if.m_ready = 1'b1;
    wait_idle("t3_idle");
    check_val("t3_n_results", n_results - r0, 8);
    check_val("t3_drain", sb_q.size(), 0);

    // Sample offered while busy is held off until IDLE
    p0 = n_pulses;
    send_sample(8'h11, c0);
    u_if.s_data  = 8'hFF;
    u_if.s_valid = 1'b1;
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (u_if.s_ready) found = 1;
    end
    check_val("t4_ready_again", found, 1'b1);
    check_val("t4_value_held", u_if.fw_value, 8'h11);
    check_val("t4_one_pulse", n_pulses - p0, 1);
    @(posedge clk); #1;
    u_if.s_valid = 1'b0;
    check_val("t4_value_new", u_if.fw_value, 8'hFF);
    wait_idle("t4_idle");
    check_val("t4_two_pulses", n_pulses - p0, 2);
    check_val("t4_drain", sb_q.size(), 0);

    // fw_active low on selections 2 and 5
    act_mask = ~8'h24;
    r0 = n_results;
    send_sample(8'h77, c0);
    wait_idle("t5_idle");
`ifdef FWSEQ_ACTIVE_GATE_EN
    check_val("t5_n_results", n_results - r0, 6);
`else
    check_val("t5_n_results", n_results - r0, 8);
`endif
    check_val("t5_drain", sb_q.size(), 0);
    act_mask = 8'hFF;

    // Minimal configuration instance
    @(posedge clk); #1;
    u_if1.s_data  = 8'hC3;
    u_if1.s_valid = 1'b1;
    @(posedge clk); #1;
    u_if1.s_valid = 1'b0;
    c0 = cyc;
    check_val("t6_fw_value", u_if1.fw_value, 8'hC3);
    found = 0; rel = -1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (u_if1.m_valid) begin
        found = 1;
        rel = cyc - c0;
      end
    end
    check_val("t6_latency", rel, 4);
    check_val("t6_m_data", u_if1.m_data, dp_model(8'hC3, 8'h01));
    check_val("t6_m_sel", u_if1.m_sel, 3'd0);
    check_val("t6_m_active", u_if1.m_active, 1'b1);
    @(negedge clk);
    check_val("t6_idle_busy", u_if1.busy, 1'b0);
    check_val("t6_idle_ready", u_if1.s_ready, 1'b1);
    check_val("t6_idle_select", u_if1.fw_select, 8'd0);
    check_val("t6_m_valid_low", u_if1.m_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
